// File: rtl/sec_cnt_pkg.sv
// Shared constants for the seconds BCD counter: digit width, default
// modulus and scan divider, active-low 7-segment codes {g,f,e,d,c,b,a}.
package sec_cnt_pkg;

  localparam int BCD_W        = 4;
  localparam int DEF_MOD      = 60;
  localparam int DEF_SCAN_DIV = 100;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Which digit the multiplexed display is currently driving.
  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment decoder; codes 10-15 blank the digit.
module bcd_to_7seg
  import sec_cnt_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [6:0]       o_seg
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sec_bcd_counter.sv
// Modulo-MOD BCD seconds counter ticked by a synchronised 1 Hz input, with a
// two-digit multiplexed 7-segment display driver.
// Optional feature: define SEC_BCD_UPDOWN_EN to honour up_dn (down counting);
// without it the counter only counts up and up_dn is ignored.
module sec_bcd_counter
  import sec_cnt_pkg::*;
#(
  parameter int MOD      = DEF_MOD,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       clk_ht,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic       carry,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam logic [BCD_W-1:0] MAX_TENS  = BCD_W'((MOD - 1) / 10);
  localparam logic [BCD_W-1:0] MAX_UNITS = BCD_W'((MOD - 1) % 10);
  localparam int               SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------- tick
  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       w_tick;

  // r_fill marks when r_sync2 holds a real post-reset sample; r_armed then
  // requires one genuine low sample, so a clk_1hz already high at reset
  // release cannot masquerade as a rising edge.
  assign w_tick = r_sync2 & ~r_hist & r_armed;

  // Synchronise clk_1hz into the clk_ht domain and keep one cycle of history.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sync1 <= clk_1hz;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_sync2);
    end
  end

  // ---------------------------------------------------------------- count
  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_units;
  logic             r_carry;
  logic [BCD_W-1:0] w_ld_tens;
  logic [BCD_W-1:0] w_ld_units;
  logic [7:0]       w_ld_bin;
  logic             w_ld_ok;
  logic [BCD_W-1:0] w_next_tens;
  logic [BCD_W-1:0] w_next_units;
  logic             w_next_wrap;

  assign w_ld_tens  = load_val[7:4];
  assign w_ld_units = load_val[3:0];
  assign w_ld_bin   = {4'd0, w_ld_tens} * 8'd10 + {4'd0, w_ld_units};
  assign w_ld_ok    = (w_ld_tens <= 4'd9) && (w_ld_units <= 4'd9) && (w_ld_bin < 8'(MOD));

`ifdef SEC_BCD_UPDOWN_EN
  // Next count value one BCD step in the selected direction, with wrap flag.
  always_comb begin
    w_next_tens  = r_tens;
    w_next_units = r_units;
    w_next_wrap  = 1'b0;
    if (up_dn) begin
      if (r_tens == MAX_TENS && r_units == MAX_UNITS) begin
        w_next_tens  = '0;
        w_next_units = '0;
        w_next_wrap  = 1'b1;
      end else if (r_units == 4'd9) begin
        w_next_tens  = r_tens + 4'd1;
        w_next_units = '0;
      end else begin
        w_next_units = r_units + 4'd1;
      end
    end else begin
      if (r_tens == '0 && r_units == '0) begin
        w_next_tens  = MAX_TENS;
        w_next_units = MAX_UNITS;
        w_next_wrap  = 1'b1;
      end else if (r_units == '0) begin
        w_next_tens  = r_tens - 4'd1;
        w_next_units = 4'd9;
      end else begin
        w_next_units = r_units - 4'd1;
      end
    end
  end
`else
  logic w_unused_up_dn;
  assign w_unused_up_dn = up_dn;

  // Next count value one BCD step up, with wrap flag.
  always_comb begin
    w_next_tens  = r_tens;
    w_next_units = r_units;
    w_next_wrap  = 1'b0;
    if (r_tens == MAX_TENS && r_units == MAX_UNITS) begin
      w_next_tens  = '0;
      w_next_units = '0;
      w_next_wrap  = 1'b1;
    end else if (r_units == 4'd9) begin
      w_next_tens  = r_tens + 4'd1;
      w_next_units = '0;
    end else begin
      w_next_units = r_units + 4'd1;
    end
  end
`endif

  // Count register: load beats an enabled tick; carry pulses only on wrap.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= '0;
      r_units <= '0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_tens  <= w_ld_ok ? w_ld_tens  : '0;
      r_units <= w_ld_ok ? w_ld_units : '0;
      r_carry <= 1'b0;
    end else if (w_tick && en) begin
      r_tens  <= w_next_tens;
      r_units <= w_next_units;
      r_carry <= w_next_wrap;
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign count_bcd = {r_tens, r_units};
  assign carry     = r_carry;

  // ---------------------------------------------------------------- display
  logic [SCAN_W-1:0] r_scan_cnt;
  slot_e             r_slot;
  logic [6:0]        r_seg;
  logic [1:0]        r_dig_sel;
  logic              w_scan_wrap;
  slot_e             w_next_slot;
  logic [BCD_W-1:0]  w_digit;
  logic [6:0]        w_seg;

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_next_slot = w_scan_wrap ? ((r_slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS) : r_slot;
  assign w_digit     = (w_next_slot == SLOT_TENS) ? r_tens : r_units;

  bcd_to_7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // Scan divider and digit slot; seg and dig_sel are registered together.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_slot     <= SLOT_UNITS;
      r_seg      <= SEG_0;
      r_dig_sel  <= 2'b10;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      r_slot     <= w_next_slot;
      r_seg      <= w_seg;
      r_dig_sel  <= (w_next_slot == SLOT_UNITS) ? 2'b10 : 2'b01;
    end
  end

  assign seg     = r_seg;
  assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_sec_bcd_counter.sv
// Bench for sec_bcd_counter: an arithmetic model of the count (integer
// modulo MOD) and of the display scan, checked every cycle, plus directed
// literal expectations.
module tb_sec_bcd_counter;

  localparam int MOD      = 60;
  localparam int SCAN_DIV = 100;

  logic       clk_ht   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clk_1hz  = 1'b0;
  logic       en       = 1'b1;
  logic       up_dn    = 1'b1;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count_bcd;
  logic       carry;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  int n_total = 0;
  int n_bad   = 0;

  sec_bcd_counter #(.MOD(MOD), .SCAN_DIV(SCAN_DIV)) dut (
    .clk_ht    (clk_ht),
    .rst_n     (rst_n),
    .clk_1hz   (clk_1hz),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .carry     (carry),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  always #5 clk_ht = ~clk_ht;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // ---------------- model: count as integer, samples of clk_1hz since reset
  int m_cnt  = 0;   // count after the latest edge
  int m_disp = 0;   // count the display decoder saw at the latest edge
  int m_k    = 0;   // clk_ht edges since reset release
  int m_n    = 0;   // clk_1hz samples taken since reset release
  bit m_carry = 1'b0;
  bit p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;  // samples 1, 2, 3 edges ago

  always @(negedge rst_n) begin
    m_cnt = 0; m_disp = 0; m_k = 0; m_n = 0; m_carry = 1'b0;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
  end

  always @(posedge clk_ht) begin
    if (rst_n) begin
      // A rising edge of clk_1hz counts on the 3rd edge after it is sampled
      // high, provided the preceding sample was a real post-reset low.
      bit tick, dir_up;
      int t, u;
      tick = (m_n >= 3) && p2 && !p3;
`ifdef SEC_BCD_UPDOWN_EN
      dir_up = up_dn;
`else
      dir_up = 1'b1;
`endif
      m_disp  = m_cnt;
      m_k++;
      m_carry = 1'b0;
      if (load) begin
        t = int'(load_val[7:4]);
        u = int'(load_val[3:0]);
        m_cnt = (t <= 9 && u <= 9 && (t * 10 + u) < MOD) ? t * 10 + u : 0;
      end else if (tick && en) begin
        if (dir_up) begin
          if (m_cnt == MOD - 1) begin m_cnt = 0; m_carry = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = MOD - 1; m_carry = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end
      p3 = p2; p2 = p1; p1 = clk_1hz; m_n++;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk_ht) begin
    if (rst_n) begin
      bit tens_slot;
      tens_slot = ((m_k / SCAN_DIV) % 2) == 1;
      check("model_count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
      check("model_carry", 32'(carry), 32'(m_carry));
      check("model_dig_sel", 32'(dig_sel), tens_slot ? 32'h1 : 32'h2);
      check("model_seg", 32'(seg), 32'(seg_of(tens_slot ? m_disp / 10 : m_disp % 10)));
    end
  end

  // ---------------- directed stimulus
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_ht);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk_ht);
    load = 1'b1; load_val = v;
    @(negedge clk_ht);
    load = 1'b0;
  endtask

  task automatic pulse_1hz();
    @(negedge clk_ht);
    clk_1hz = 1'b1;
    wait_neg(6);
    clk_1hz = 1'b0;
    wait_neg(6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, 32'(count_bcd), 32'h00);
    check({tag, "_carry"}, 32'(carry), 32'h0);
    check({tag, "_dig_sel"}, 32'(dig_sel), 32'h2);
    check({tag, "_seg"}, 32'(seg), 32'b1000000);
  endtask

  initial begin
    int last_change, n_changes;
    logic [1:0] prev_sel;

    // Reset values, then first tick lands on the 3rd edge.
    #23;
    check_reset_vals("reset");
    @(negedge clk_ht);
    rst_n = 1'b1;
    wait_neg(5);
    clk_1hz = 1'b1;
    wait_neg(2);
    check("first_tick_pre", 32'(count_bcd), 32'h00);
    wait_neg(1);
    check("first_tick", 32'(count_bcd), 32'h01);
    check("first_tick_carry", 32'(carry), 32'h0);
    wait_neg(4);
    clk_1hz = 1'b0;
    wait_neg(6);

    // Up wrap 58 -> 59 -> 00 with one-cycle carry.
    do_load(8'h58);
    check("load_58", 32'(count_bcd), 32'h58);
    pulse_1hz();
    check("up_59", 32'(count_bcd), 32'h59);
    @(negedge clk_ht);
    clk_1hz = 1'b1;
    wait_neg(3);
    check("up_wrap_00", 32'(count_bcd), 32'h00);
    check("up_wrap_carry", 32'(carry), 32'h1);
    wait_neg(1);
    check("up_wrap_carry_drop", 32'(carry), 32'h0);
    wait_neg(3);
    clk_1hz = 1'b0;
    wait_neg(6);

    // Down from 00: wraps to 59 only when down counting is built in.
    up_dn = 1'b0;
    @(negedge clk_ht);
    clk_1hz = 1'b1;
    wait_neg(3);
`ifdef SEC_BCD_UPDOWN_EN
    check("down_wrap_59", 32'(count_bcd), 32'h59);
    check("down_wrap_carry", 32'(carry), 32'h1);
`else
    check("down_ignored_01", 32'(count_bcd), 32'h01);
    check("down_ignored_carry", 32'(carry), 32'h0);
`endif
    wait_neg(3);
    clk_1hz = 1'b0;
    up_dn = 1'b1;
    wait_neg(6);

    // Load validation.
    do_load(8'h3A);
    check("load_3A", 32'(count_bcd), 32'h00);
    do_load(8'h75);
    check("load_75", 32'(count_bcd), 32'h00);
    do_load(8'h42);
    check("load_42", 32'(count_bcd), 32'h42);
    do_load(8'h60);
    check("load_60", 32'(count_bcd), 32'h00);
    do_load(8'h42);

    // Load coincident with a tick: the loaded value wins.
    @(negedge clk_ht);
    clk_1hz = 1'b1;
    wait_neg(2);
    load = 1'b1; load_val = 8'h17;
    wait_neg(1);
    load = 1'b0;
    check("load_beats_tick", 32'(count_bcd), 32'h17);
    wait_neg(3);
    check("load_beats_tick_hold", 32'(count_bcd), 32'h17);
    clk_1hz = 1'b0;
    wait_neg(6);

    // Disabled: ticks are discarded.
    en = 1'b0;
    pulse_1hz();
    pulse_1hz();
    check("en_low_hold", 32'(count_bcd), 32'h17);
    en = 1'b1;

    // Display scan on 42.
    do_load(8'h42);
    wait_neg(2);
    last_change = -1;
    n_changes   = 0;
    prev_sel    = dig_sel;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_ht);
      if (dig_sel == 2'b10) check("scan_units_seg", 32'(seg), 32'b0100100);
      else                  check("scan_tens_seg", 32'(seg), 32'b0011001);
      if (dig_sel != prev_sel) begin
        if (last_change >= 0) check("scan_period", 32'(i - last_change), 32'd100);
        last_change = i;
        n_changes++;
      end
      prev_sel = dig_sel;
    end
    check("scan_changes", 32'(n_changes >= 3), 32'h1);

    // Reset while carry and clk_1hz are high.
    do_load(8'h59);
    @(negedge clk_ht);
    clk_1hz = 1'b1;
    wait_neg(3);
    check("pre_reset_carry", 32'(carry), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(8);
    check("no_tick_after_release", 32'(count_bcd), 32'h00);
    clk_1hz = 1'b0;
    wait_neg(5);
    clk_1hz = 1'b1;
    wait_neg(3);
    check("tick_after_release", 32'(count_bcd), 32'h01);
    wait_neg(4);
    clk_1hz = 1'b0;
    wait_neg(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
